// File: rtl/conv_core_gen2_pkg.sv
// Shared types and index helpers for the second-generation convolution engine.
// Optional build macro used elsewhere in this slice: CONV_SATURATE_EN.
package conv_gen2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        MAC    = 3'd2,
        DRAIN  = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Wide enough that a full-length sum of extreme products cannot overflow.
    function automatic int acc_width(input int dw, input int axw, input int ayw);
        return 2 * dw + max_int(axw, ayw) + 1;
    endfunction

    function automatic int kmin_calc(input int n, input int size_y);
        return max_int(0, n - size_y + 1);
    endfunction

    function automatic int kmax_calc(input int n, input int size_x);
        return min_int(n, size_x - 1);
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Multiply-accumulate datapath: extends each product per signed_mode and sums it.
// With CONV_SATURATE_EN defined the result is clamped, otherwise truncated.
module conv_mac_unit
    import conv_gen2_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_X_WIDTH = 5,
    parameter int ADDR_Y_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] op_x,
    input  logic [DATA_WIDTH-1:0] op_y,
    input  logic                  signed_mode,
    input  logic                  clear,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int ACC_W = acc_width(DATA_WIDTH, ADDR_X_WIDTH, ADDR_Y_WIDTH);

    logic signed [DATA_WIDTH:0]     x_ext;
    logic signed [DATA_WIDTH:0]     y_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        acc_nxt;

    // One extra operand bit lets a single signed multiplier serve both modes.
    assign x_ext    = {signed_mode & op_x[DATA_WIDTH-1], op_x};
    assign y_ext    = {signed_mode & op_y[DATA_WIDTH-1], op_y};
    assign prod     = x_ext * y_ext;
    assign prod_ext = {{(ACC_W - 2*DATA_WIDTH){signed_mode & prod[2*DATA_WIDTH-1]}}, prod};
    assign acc_nxt  = acc_q + (enable ? prod_ext : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_nxt;
        end
    end

    // result reflects the accumulator including this cycle's product.
`ifdef CONV_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] S_MAX = (ONE <<< (DATA_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] S_MIN = -(ONE <<< (DATA_WIDTH - 1));
    localparam logic signed [ACC_W-1:0] U_MAX = (ONE <<< DATA_WIDTH) - ONE;

    always_comb begin
        result = acc_nxt[DATA_WIDTH-1:0];
        if (signed_mode) begin
            if (acc_nxt > S_MAX) begin
                result = S_MAX[DATA_WIDTH-1:0];
            end else if (acc_nxt < S_MIN) begin
                result = S_MIN[DATA_WIDTH-1:0];
            end
        end else if (acc_nxt > U_MAX) begin
            result = U_MAX[DATA_WIDTH-1:0];
        end
    end
`else
    assign result = acc_nxt[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/conv_core_gen2.sv
// Convolution engine top: sequencing FSM, index counters and X/Y/Z memory interface.
// Result saturation is selected at build time with CONV_SATURATE_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on start
// CHECK  | validate sizes, load index range for n=0
// MAC    | issue one X/Y address pair per cycle for current n
// DRAIN  | accumulate last product, register Z write
// WRITE  | writeZ high; advance n or finish
// FINISH | last busy cycle; done pulses next cycle
module conv_core_gen2
    import conv_gen2_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_X_WIDTH = 5,
    parameter int ADDR_Y_WIDTH = 5,
    parameter int ADDR_Z_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    signed_mode,
    input  logic [ADDR_X_WIDTH:0]   sizeX,
    input  logic [ADDR_Y_WIDTH:0]   sizeY,
    output logic [ADDR_X_WIDTH-1:0] memX_addr,
    input  logic [DATA_WIDTH-1:0]   dataX,
    output logic [ADDR_Y_WIDTH-1:0] memY_addr,
    input  logic [DATA_WIDTH-1:0]   dataY,
    output logic [ADDR_Z_WIDTH-1:0] memZ_addr,
    output logic [DATA_WIDTH-1:0]   dataZ,
    output logic                    writeZ,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [ADDR_X_WIDTH:0] SX_MAX = {1'b1, {ADDR_X_WIDTH{1'b0}}};
    localparam logic [ADDR_Y_WIDTH:0] SY_MAX = {1'b1, {ADDR_Y_WIDTH{1'b0}}};

    state_e                  state_q;
    logic [ADDR_X_WIDTH:0]   sx_q;
    logic [ADDR_Y_WIDTH:0]   sy_q;
    logic                    sm_q;
    logic [ADDR_Z_WIDTH-1:0] n_q;
    logic [ADDR_Z_WIDTH-1:0] n_nxt;
    logic [ADDR_X_WIDTH-1:0] k_q;
    logic [ADDR_X_WIDTH-1:0] k_end_q;
    logic                    issue_q;
    logic                    size_bad;
    logic                    last_n;
    logic                    load_range;
    logic [DATA_WIDTH-1:0]   mac_result;
    int                      n_nxt_i;
    int                      kmin_i;
    int                      kmax_i;

    assign size_bad   = (sx_q == '0) || (sy_q == '0) || (sx_q > SX_MAX) || (sy_q > SY_MAX);
    assign last_n     = int'(n_q) == int'(sx_q) + int'(sy_q) - 2;
    assign n_nxt      = (state_q == CHECK) ? '0 : n_q + ADDR_Z_WIDTH'(1);
    assign load_range = ((state_q == CHECK) && !size_bad) || ((state_q == WRITE) && !last_n);

    always_comb begin
        n_nxt_i = int'(n_nxt);
        kmin_i  = kmin_calc(n_nxt_i, int'(sy_q));
        kmax_i  = kmax_calc(n_nxt_i, int'(sx_q));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            sm_q      <= 1'b0;
            n_q       <= '0;
            k_q       <= '0;
            k_end_q   <= '0;
            issue_q   <= 1'b0;
            memX_addr <= '0;
            memY_addr <= '0;
            memZ_addr <= '0;
            dataZ     <= '0;
            writeZ    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            issue_q <= (state_q == MAC);
            writeZ  <= (state_q == DRAIN);
            done    <= (state_q == FINISH);

            // First address pair of each n must be on the bus in the first MAC cycle.
            if (load_range) begin
                n_q       <= n_nxt;
                k_q       <= ADDR_X_WIDTH'(kmin_i);
                k_end_q   <= ADDR_X_WIDTH'(kmax_i);
                memX_addr <= ADDR_X_WIDTH'(kmin_i);
                memY_addr <= ADDR_Y_WIDTH'(n_nxt_i - kmin_i);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        sx_q    <= sizeX;
                        sy_q    <= sizeY;
                        sm_q    <= signed_mode;
                        busy    <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    err     <= size_bad;
                    state_q <= size_bad ? FINISH : MAC;
                end
                MAC: begin
                    if (k_q == k_end_q) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q       <= k_q + ADDR_X_WIDTH'(1);
                        memX_addr <= k_q + ADDR_X_WIDTH'(1);
                        memY_addr <= memY_addr - ADDR_Y_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    memZ_addr <= n_q;
                    dataZ     <= mac_result;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    state_q <= last_n ? FINISH : MAC;
                end
                FINISH: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    conv_mac_unit #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_X_WIDTH (ADDR_X_WIDTH),
        .ADDR_Y_WIDTH (ADDR_Y_WIDTH)
    ) u_mac (
        .clk         (clk),
        .rstn        (rstn),
        .op_x        (dataX),
        .op_y        (dataY),
        .signed_mode (sm_q),
        .clear       (load_range),
        .enable      (issue_q),
        .result      (mac_result)
    );

endmodule
